// File: rtl/elevator_car_ctrl_if.sv
// Call/status bundle between the building scheduler (master) and one car controller (slave).
interface elevator_car_ctrl_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
);
    logic                  tick;
    logic [NUM_FLOORS-1:0] call_req;
    logic                  door_hold;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  up_ndown;
    logic                  moving;
    logic                  door_open;
    logic [1:0]            state;
    logic [NUM_FLOORS-1:0] pending;
    logic                  arrived;

    modport master (
        output tick, call_req, door_hold,
        input  current_floor, up_ndown, moving, door_open, state, pending, arrived
    );

    modport slave (
        input  tick, call_req, door_hold,
        output current_floor, up_ndown, moving, door_open, state, pending, arrived
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Single-car SCAN elevator controller timed by an external tick strobe.
// Optional door-hold / same-floor reopen feature: define ELEVATOR_DOOR_HOLD_EN.
module elevator_car_ctrl #(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned FLOOR_W      = $clog2(NUM_FLOORS),
    parameter int unsigned PREP_TICKS   = 2,
    parameter int unsigned TRAVEL_TICKS = 5,
    parameter int unsigned DOOR_TICKS   = 5,
    parameter int unsigned PARK_FLOOR   = 0
) (
    input  logic           clk,
    input  logic           reset,
    elevator_car_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        StParked    = 2'b00,
        StPrepare   = 2'b01,
        StMove      = 2'b11,
        StDisembark = 2'b10
    } state_e;

    localparam int unsigned MAX_A     = (PREP_TICKS > TRAVEL_TICKS) ? PREP_TICKS : TRAVEL_TICKS;
    localparam int unsigned MAX_TICKS = (MAX_A > DOOR_TICKS) ? MAX_A : DOOR_TICKS;
    localparam int unsigned TIMER_W   = $clog2(MAX_TICKS + 1);

    localparam logic [TIMER_W-1:0] PREP_LAST   = TIMER_W'(PREP_TICKS - 1);
    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_e                state_q;
    logic [FLOOR_W-1:0]    floor_q;
    logic                  up_q;
    logic                  moving_q;
    logic                  door_q;
    logic                  arrived_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [TIMER_W-1:0]    timer_q;
    logic                  stepped_q;

    logic [NUM_FLOORS-1:0] floor_mask;
    logic [NUM_FLOORS-1:0] pending_merged;
    logic                  any_above;
    logic                  any_below;
    logic                  ahead;
    logic                  behind;
    logic                  here;
    logic                  hold;

    always_comb begin
        floor_mask          = '0;
        floor_mask[floor_q] = 1'b1;
        any_above           = 1'b0;
        any_below           = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (pending_q[f] && (FLOOR_W'(f) > floor_q)) any_above = 1'b1;
            if (pending_q[f] && (FLOOR_W'(f) < floor_q)) any_below = 1'b1;
        end
        ahead  = up_q ? any_above : any_below;
        behind = up_q ? any_below : any_above;
        here   = |(pending_q & floor_mask);
        // Calls for the floor whose door is open are already being served.
        pending_merged = pending_q | bus.call_req;
        if (state_q == StDisembark) pending_merged = pending_merged & ~floor_mask;
    end

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign hold = bus.door_hold | (|(bus.call_req & floor_mask));
`else
    logic unused_door_hold;
    assign unused_door_hold = bus.door_hold;
    assign hold             = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StParked;
            floor_q   <= FLOOR_W'(PARK_FLOOR);
            up_q      <= 1'b1;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
            arrived_q <= 1'b0;
            pending_q <= '0;
            timer_q   <= '0;
            stepped_q <= 1'b0;
        end else begin
            pending_q <= pending_merged;
            arrived_q <= 1'b0;
            case (state_q)
                StParked: begin
                    timer_q <= '0;
                    if (here) begin
                        state_q   <= StDisembark;
                        door_q    <= 1'b1;
                        arrived_q <= 1'b1;
                        pending_q <= pending_merged & ~floor_mask;
                    end else if (|pending_q) begin
                        state_q <= StPrepare;
                        up_q    <= any_above;
                    end
                end
                StPrepare: begin
                    if (bus.tick) begin
                        if (timer_q == PREP_LAST) begin
                            state_q   <= StMove;
                            moving_q  <= 1'b1;
                            timer_q   <= '0;
                            stepped_q <= 1'b0;
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                end
                StMove: begin
                    // Stop check only happens on the cycle right after a floor step.
                    if (stepped_q && here) begin
                        state_q   <= StDisembark;
                        moving_q  <= 1'b0;
                        door_q    <= 1'b1;
                        arrived_q <= 1'b1;
                        timer_q   <= '0;
                        stepped_q <= 1'b0;
                        pending_q <= pending_merged & ~floor_mask;
                    end else begin
                        stepped_q <= 1'b0;
                        if (bus.tick) begin
                            if (timer_q == TRAVEL_LAST) begin
                                timer_q   <= '0;
                                stepped_q <= 1'b1;
                                if (up_q && (floor_q != TOP_FLOOR)) begin
                                    floor_q <= floor_q + FLOOR_W'(1);
                                end else if (!up_q && (floor_q != '0)) begin
                                    floor_q <= floor_q - FLOOR_W'(1);
                                end
                            end else begin
                                timer_q <= timer_q + TIMER_W'(1);
                            end
                        end
                    end
                end
                StDisembark: begin
                    if (hold) begin
                        timer_q <= '0;
                    end else if (bus.tick) begin
                        if (timer_q == DOOR_LAST) begin
                            door_q  <= 1'b0;
                            timer_q <= '0;
                            if (ahead) begin
                                state_q <= StPrepare;
                            end else if (behind) begin
                                state_q <= StPrepare;
                                up_q    <= ~up_q;
                            end else begin
                                state_q <= StParked;
                            end
                        end else begin
                            timer_q <= timer_q + TIMER_W'(1);
                        end
                    end
                end
                default: state_q <= StParked;
            endcase
        end
    end

    assign bus.current_floor = floor_q;
    assign bus.up_ndown      = up_q;
    assign bus.moving        = moving_q;
    assign bus.door_open     = door_q;
    assign bus.state         = state_q;
    assign bus.pending       = pending_q;
    assign bus.arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Scoreboard bench for elevator_car_ctrl: expected car events are queued by the stimulus,
// a monitor pops one per state/floor change (or on a snapshot request) and compares.
module tb_elevator_car_ctrl;
    localparam int unsigned NF = 8;
    localparam logic [1:0] ST_P = 2'b00, ST_R = 2'b01, ST_M = 2'b11, ST_D = 2'b10;
`ifdef ELEVATOR_DOOR_HOLD_EN
    localparam int HOLD_GAP   = 15;
    localparam int RECALL_GAP = 7;
`else
    localparam int HOLD_GAP   = 5;
    localparam int RECALL_GAP = 5;
`endif

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] flr;
        logic       up;
        logic       mov;
        logic       door;
        logic       arr;
        logic [7:0] pend;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
        bit    from_stim;
        string name;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    elevator_car_ctrl_if #(.NUM_FLOORS(NF)) bus ();
    elevator_car_ctrl #(.NUM_FLOORS(NF)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   stim_cyc = 0;
    int   last_ev  = 0;
    bit   snap_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t sample();
        snap_t s;
        s = {bus.state, bus.current_floor, bus.up_ndown, bus.moving, bus.door_open,
             bus.arrived, bus.pending};
        return s;
    endfunction

    task automatic ev(input logic [1:0] st, input int flr, input logic up, input logic [7:0] pend,
                      input int gap, input bit fs, input string name);
        exp_t e;
        e.s.st     = st;
        e.s.flr    = 3'(flr);
        e.s.up     = up;
        e.s.mov    = (st == ST_M);
        e.s.door   = (st == ST_D);
        e.s.arr    = (st == ST_D);
        e.s.pend   = pend;
        e.gap      = gap;
        e.from_stim = fs;
        e.name     = name;
        exp_q.push_back(e);
    endtask

    // One MOVE event per floor step, 5 ticks apart.
    task automatic travel(input int from, input int to, input logic up, input logic [7:0] pend,
                          input string name);
        int f;
        f = from;
        while (f != to) begin
            f = up ? f + 1 : f - 1;
            ev(ST_M, f, up, pend, 5, 1'b0, name);
        end
    endtask

    task automatic pulse_call(input logic [7:0] m);
        @(posedge clk);
        #1 bus.call_req = m;
        stim_cyc = cyc;
        @(posedge clk);
        #1 bus.call_req = '0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: actual %0d events outstanding, required 0 (next %s)",
                     name, exp_q.size(), exp_q[0].name);
            exp_q.delete();
        end
    endtask

    task automatic wait_move_floor(input int flr, input logic up, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            hit = (bus.state == ST_M) && (bus.current_floor == 3'(flr)) && (bus.up_ndown == up);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s_reach: actual floor %0d state %b, required MOVE at floor %0d",
                     name, bus.current_floor, bus.state, flr);
        end
    endtask

    // Monitor: one expected entry per observed state/floor change or snapshot request.
    initial begin
        snap_t cur, prev;
        exp_t  e;
        bit    primed, changed;
        int    g;
        primed = 1'b0;
        forever begin
            @(negedge clk);
            cur     = sample();
            changed = primed && ((cur.st != prev.st) || (cur.flr != prev.flr));
            if (snap_req || changed) begin
                snap_req = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: actual %h, required no event", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.s) begin
                        errors++;
                        $display("FAIL %s: actual st=%b flr=%0d up=%b mov=%b door=%b arr=%b pend=%h, required st=%b flr=%0d up=%b mov=%b door=%b arr=%b pend=%h",
                                 e.name, cur.st, cur.flr, cur.up, cur.mov, cur.door, cur.arr,
                                 cur.pend, e.s.st, e.s.flr, e.s.up, e.s.mov, e.s.door, e.s.arr,
                                 e.s.pend);
                    end
                    if (e.gap >= 0) begin
                        checks++;
                        g = e.from_stim ? (cyc - stim_cyc) : (cyc - last_ev);
                        if (g != e.gap) begin
                            errors++;
                            $display("FAIL %s_timing: actual %0d cycles, required %0d",
                                     e.name, g, e.gap);
                        end
                    end
                end
            end
            if (changed) last_ev = cyc;
            prev   = cur;
            primed = 1'b1;
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.tick      = 1'b1;
        bus.call_req  = '0;
        bus.door_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        ev(ST_P, 0, 1'b1, 8'h00, -1, 1'b0, "reset_state");
        snap_req = 1'b1;
        drain("reset");

        // 1: floor 0 -> 3
        ev(ST_R, 0, 1'b1, 8'h08, 2, 1'b1, "t1_prepare");
        ev(ST_M, 0, 1'b1, 8'h08, 2, 1'b0, "t1_move");
        travel(0, 3, 1'b1, 8'h08, "t1_step");
        ev(ST_D, 3, 1'b1, 8'h00, 1, 1'b0, "t1_arrive");
        ev(ST_P, 3, 1'b1, 8'h00, 5, 1'b0, "t1_park");
        pulse_call(8'h08);
        drain("t1");

        // 2: same-floor call while parked, then a repeat call while the door is open
        ev(ST_D, 3, 1'b1, 8'h00, 2, 1'b1, "t2_open");
        ev(ST_P, 3, 1'b1, 8'h00, RECALL_GAP, 1'b0, "t2_close");
        pulse_call(8'h08);
        @(posedge clk);
        @(posedge clk);
        #1 bus.call_req = 8'h08;
        @(posedge clk);
        #1 bus.call_req = '0;
        drain("t2");

        // 3a: move down to floor 2
        ev(ST_R, 3, 1'b0, 8'h04, 2, 1'b1, "t3_down_prepare");
        ev(ST_M, 3, 1'b0, 8'h04, 2, 1'b0, "t3_down_move");
        travel(3, 2, 1'b0, 8'h04, "t3_down_step");
        ev(ST_D, 2, 1'b0, 8'h00, 1, 1'b0, "t3_down_arrive");
        ev(ST_P, 2, 1'b0, 8'h00, 5, 1'b0, "t3_down_park");
        pulse_call(8'h04);
        drain("t3a");

        // 3b: 2 -> 6 with calls 4 and 0 raised at floor 3
        ev(ST_R, 2, 1'b1, 8'h40, 2, 1'b1, "t3_prepare");
        ev(ST_M, 2, 1'b1, 8'h40, 2, 1'b0, "t3_move");
        travel(2, 3, 1'b1, 8'h40, "t3_step");
        travel(3, 4, 1'b1, 8'h51, "t3_step4");
        ev(ST_D, 4, 1'b1, 8'h41, 1, 1'b0, "t3_arrive4");
        ev(ST_R, 4, 1'b1, 8'h41, 5, 1'b0, "t3_prepare4");
        ev(ST_M, 4, 1'b1, 8'h41, 2, 1'b0, "t3_move4");
        travel(4, 6, 1'b1, 8'h41, "t3_step6");
        ev(ST_D, 6, 1'b1, 8'h01, 1, 1'b0, "t3_arrive6");
        ev(ST_R, 6, 1'b0, 8'h01, 5, 1'b0, "t3_reverse");
        ev(ST_M, 6, 1'b0, 8'h01, 2, 1'b0, "t3_move_down");
        travel(6, 0, 1'b0, 8'h01, "t3_step_down");
        ev(ST_D, 0, 1'b0, 8'h00, 1, 1'b0, "t3_arrive0");
        ev(ST_P, 0, 1'b0, 8'h00, 5, 1'b0, "t3_park");
        pulse_call(8'h40);
        wait_move_floor(3, 1'b1, "t3");
        @(posedge clk);
        #1 bus.call_req = 8'h11;
        @(posedge clk);
        #1 bus.call_req = '0;
        drain("t3b");

        // 4: calls 0 and 7 together at floor 0
        ev(ST_D, 0, 1'b0, 8'h80, 2, 1'b1, "t4_open0");
        ev(ST_R, 0, 1'b1, 8'h80, 5, 1'b0, "t4_prepare");
        ev(ST_M, 0, 1'b1, 8'h80, 2, 1'b0, "t4_move");
        travel(0, 7, 1'b1, 8'h80, "t4_step");
        ev(ST_D, 7, 1'b1, 8'h00, 1, 1'b0, "t4_arrive7");
        ev(ST_P, 7, 1'b1, 8'h00, 5, 1'b0, "t4_park");
        pulse_call(8'h81);
        drain("t4");
        repeat (20) @(posedge clk);

        // 5: reset while parked at 7, then reset in MOVE at floor 3 with pending 0x90
        ev(ST_P, 0, 1'b1, 8'h00, -1, 1'b0, "t5_reset_parked");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drain("t5a");
        ev(ST_R, 0, 1'b1, 8'h80, 2, 1'b1, "t5_prepare");
        ev(ST_M, 0, 1'b1, 8'h80, 2, 1'b0, "t5_move");
        travel(0, 3, 1'b1, 8'h80, "t5_step");
        pulse_call(8'h80);
        wait_move_floor(3, 1'b1, "t5");
        @(posedge clk);
        #1 bus.call_req = 8'h10;
        @(posedge clk);
        #1 bus.call_req = '0;
        ev(ST_M, 3, 1'b1, 8'h90, -1, 1'b0, "t5_pending");
        snap_req = 1'b1;
        ev(ST_P, 0, 1'b1, 8'h00, -1, 1'b0, "t5_reset_move");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        drain("t5b");

        // 6: door hold for 10 ticks from door open
        ev(ST_D, 0, 1'b1, 8'h00, 2, 1'b1, "t6_open");
        ev(ST_P, 0, 1'b1, 8'h00, HOLD_GAP, 1'b0, "t6_close");
        pulse_call(8'h01);
        @(posedge clk);
        #1 bus.door_hold = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.door_hold = 1'b0;
        drain("t6");

        repeat (30) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
